// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART byte receiver.
// Optional even-parity support is enabled in uart_byte_rx by defining UART_RX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

  localparam int unsigned DEF_CLK_HZ = 50_000_000;
  localparam int unsigned DEF_BAUD   = 115200;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Mid-bit sample point at the default line rate; modules derive their own from parameters.
  localparam int unsigned MID = clks_per_bit(DEF_CLK_HZ, DEF_BAUD) / 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-FF synchronizer, bit-period counter and 3-sample majority vote.
// bit_valid marks the cycle in which bit_val holds the voted value for the current bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CPB = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic rxpin,
  input  logic restart,
  output logic rx_s,
  output logic fall_edge,
  output logic bit_valid,
  output logic bit_val
);

  localparam int unsigned BC_W    = $clog2(CPB);
  localparam int unsigned MID_CNT = CPB / 2;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(CPB - 1);
  localparam logic [BC_W-1:0] SAMP_A  = BC_W'(MID_CNT - 1);
  localparam logic [BC_W-1:0] SAMP_B  = BC_W'(MID_CNT);
  localparam logic [BC_W-1:0] SAMP_C  = BC_W'(MID_CNT + 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            prev_q;
  logic [BC_W-1:0] bc_q;
  logic [BC_W-1:0] bc_d;
  logic            samp_a_q;
  logic            samp_b_q;

  // Synchronizer and edge history reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      bc_q     <= '0;
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
    end else begin
      sync1_q <= rxpin;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      bc_q    <= bc_d;
      if (bc_q == SAMP_A) samp_a_q <= sync2_q;
      if (bc_q == SAMP_B) samp_b_q <= sync2_q;
    end
  end

  // Bit counter re-aligns on a start edge, otherwise free-runs over one bit period.
  always_comb begin
    bc_d = bc_q + BC_W'(1);
    if (restart || (bc_q == BC_LAST)) bc_d = '0;
  end

  assign rx_s      = sync2_q;
  assign fall_edge = prev_q & ~sync2_q;
  assign bit_valid = (bc_q == SAMP_C);
  assign bit_val   = maj3(samp_a_q, samp_b_q, sync2_q);

endmodule

// File: rtl/uart_byte_rx.sv
// UART 8N1 byte receiver with glitch rejection and framing-error strobe.
// Define UART_RX_PARITY_EN for 8E1 framing and the parity_err strobe.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxpin,
  output logic [DATA_BITS-1:0] out_byte,
  output logic                 out_byte_ok,
  output logic                 frame_err,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int unsigned CPB   = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  rx_state_e            state_q;
  rx_state_e            state_d;
  logic                 rx_s;
  logic                 fall_edge;
  logic                 bit_valid;
  logic                 bit_val;
  logic                 restart_c;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [DATA_BITS-1:0] out_byte_q;
  logic [DATA_BITS-1:0] out_byte_d;
  logic                 ok_q;
  logic                 ok_d;
  logic                 ferr_q;
  logic                 ferr_d;
  logic                 busy_q;
  logic                 busy_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q;
  logic                 par_bad_d;
  logic                 perr_q;
  logic                 perr_d;
`endif

  uart_rx_sampler #(
    .CPB (CPB)
  ) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .rxpin     (rxpin),
    .restart   (restart_c),
    .rx_s      (rx_s),
    .fall_edge (fall_edge),
    .bit_valid (bit_valid),
    .bit_val   (bit_val)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; STOP returns to IDLE mid-stop-bit so a following start edge is caught.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (fall_edge) state_d = START;
      START:     if (bit_valid) state_d = bit_val ? IDLE : DATA;
      DATA: begin
        if (bit_valid && (idx_q == LAST_IDX)) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY:    if (bit_valid) state_d = STOP;
      STOP:      if (bit_valid) state_d = bit_val ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath and strobe next values.
  always_comb begin
    restart_c  = (state_q == IDLE) && fall_edge;
    idx_d      = idx_q;
    shift_d    = shift_q;
    out_byte_d = out_byte_q;
    ok_d       = 1'b0;
    ferr_d     = 1'b0;
    busy_d     = (state_d != IDLE);
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    perr_d     = 1'b0;
`endif
    case (state_q)
      START: begin
        if (bit_valid && !bit_val) begin
          idx_d = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      DATA: begin
        if (bit_valid) begin
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_valid) par_bad_d = bit_val ^ (^shift_q);
      end
`endif
      STOP: begin
        if (bit_valid) begin
          if (!bit_val) begin
            ferr_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_bad_q) begin
            perr_d = 1'b1;
          end
`endif
          else begin
            out_byte_d = shift_q;
            ok_d       = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      shift_q    <= '0;
      out_byte_q <= '0;
      ok_q       <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      out_byte_q <= out_byte_d;
      ok_q       <= ok_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= par_bad_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign out_byte    = out_byte_q;
  assign out_byte_ok = ok_q;
  assign frame_err   = ferr_q;
  assign busy        = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_q;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: directed frames plus randomized traffic
// compared against a frame-level reference model.
module tb_uart_byte_rx;

  localparam int unsigned CLK_HZ = 1_600_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned CPB    = CLK_HZ / BAUD;
  localparam int unsigned MIDB   = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rxpin;
  logic [7:0] out_byte;
  logic       out_byte_ok;
  logic       frame_err;
  logic       busy;
  logic       parity_err;
`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_byte_rx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .DATA_BITS (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rxpin       (rxpin),
    .out_byte    (out_byte),
    .out_byte_ok (out_byte_ok),
    .frame_err   (frame_err),
    .busy        (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         last_ok_cyc = 0;
  int         got_fe = 0, exp_fe = 0;
  int         got_pe = 0, exp_pe = 0;
  int         multi_cnt = 0;
  logic [7:0] got_bytes[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] last_good = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: collects strobes away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_byte_ok) begin
        got_bytes.push_back(out_byte);
        last_ok_cyc = cyc;
      end
      if (frame_err) got_fe++;
      if (parity_err) got_pe++;
      if ((int'(out_byte_ok) + int'(frame_err) + int'(parity_err)) > 1) multi_cnt++;
    end
  end

  task automatic bit_time(input logic lvl);
    rxpin = lvl;
    repeat (CPB) @(negedge clk);
  endtask

  // Serialize one frame and record what the receiver must report for it.
  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input logic par_flip);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    if (P == 1) bit_time((^d) ^ par_flip);
    bit_time(stop_lvl);
    if (!stop_lvl) exp_fe++;
    else if ((P == 1) && par_flip) exp_pe++;
    else begin
      exp_bytes.push_back(d);
      last_good = d;
    end
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, 32'(got_bytes.size()), 32'(exp_bytes.size()));
    for (int i = 0; (i < got_bytes.size()) && (i < exp_bytes.size()); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_bytes[i]), 32'(exp_bytes[i]));
    check({tag, "_frame_err"}, 32'(got_fe), 32'(exp_fe));
    check({tag, "_parity_err"}, 32'(got_pe), 32'(exp_pe));
    got_bytes.delete();
    exp_bytes.delete();
  endtask

  initial begin
    int         t0;
    int         lat;
    logic       saw_busy;
    logic [7:0] d;
    logic       stop_bad;
    logic       flip;

    rst   = 1'b1;
    rxpin = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out_byte", 32'(out_byte), 32'h0);
    check("reset_ok", 32'(out_byte_ok), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    bit_time(1'b1);
    bit_time(1'b1);

    // 1: single frame, strobe latency
    t0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    lat = last_ok_cyc - t0;
    check("t1_latency_window",
          32'((lat >= int'((9 + P) * CPB + MIDB + 2)) && (lat <= int'((9 + P) * CPB + MIDB + 6))),
          32'h1);
    bit_time(1'b1);
    compare_stream("t1");
    check("t1_out_byte", 32'(out_byte), 32'hA5);

    // 2: back-to-back frames with zero idle
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    bit_time(1'b1);
    compare_stream("t2");

    // 3: short low pulse is rejected as a false start
    saw_busy = 1'b0;
    rxpin = 1'b0;
    repeat ((CPB * 3) / 10) begin
      @(negedge clk);
      saw_busy = saw_busy | busy;
    end
    rxpin = 1'b1;
    repeat (CPB) begin
      @(negedge clk);
      saw_busy = saw_busy | busy;
    end
    check("t3_saw_busy", 32'(saw_busy), 32'h1);
    check("t3_busy_idle", 32'(busy), 32'h0);
    compare_stream("t3");

    // 4: stop bit low, line held low, then a good frame
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (19) bit_time(1'b0);
    check("t4_busy_in_break", 32'(busy), 32'h1);
    check("t4_out_byte_kept", 32'(out_byte), 32'(last_good));
    bit_time(1'b1);
    send_frame(8'h12, 1'b1, 1'b0);
    bit_time(1'b1);
    compare_stream("t4");

    // 5: one-clock glitch at the middle of data bit 3 of 0x00
    rxpin = 1'b0;
    for (int k = 0; k < int'((9 + P) * CPB); k++) begin
      rxpin = (k == int'(4 * CPB + MIDB));
      @(negedge clk);
    end
    bit_time(1'b1);
    exp_bytes.push_back(8'h00);
    last_good = 8'h00;
    bit_time(1'b1);
    compare_stream("t5");

    // 6: reset during bit 4 of 0xC3, then a clean frame
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'(8'hC3 >> i));
    rxpin = 1'b0;
    repeat (MIDB) @(negedge clk);
    rst   = 1'b1;
    rxpin = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("t6_busy_after_rst", 32'(busy), 32'h0);
    check("t6_out_byte_after_rst", 32'(out_byte), 32'h0);
    last_good = 8'h00;
    bit_time(1'b1);
    bit_time(1'b1);
    send_frame(8'h81, 1'b1, 1'b0);
    bit_time(1'b1);
    compare_stream("t6");

`ifdef UART_RX_PARITY_EN
    // Parity mismatch with a good stop bit
    send_frame(8'h7E, 1'b1, 1'b1);
    bit_time(1'b1);
    check("par_out_byte_kept", 32'(out_byte), 32'(last_good));
    compare_stream("par");
`endif

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      d        = 8'($urandom);
      stop_bad = ($urandom_range(0, 7) == 0);
      flip     = (P == 1) && ($urandom_range(0, 5) == 0);
      send_frame(d, !stop_bad, flip);
      if (stop_bad) begin
        repeat ($urandom_range(1, 3)) bit_time(1'b0);
        bit_time(1'b1);
      end else begin
        repeat ($urandom_range(0, 2)) bit_time(1'b1);
      end
    end
    bit_time(1'b1);
    bit_time(1'b1);
    compare_stream("rand");
    check("rand_out_byte", 32'(out_byte), 32'(last_good));
    check("strobes_exclusive", 32'(multi_cnt), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
